// File: rtl/ex_muldiv_ctrl.sv
// ex_muldiv_ctrl: EX-stage result-select and multiply/divide sequencing controller.
//
// Decodes the EX operation class into a one-hot result select. Single-cycle
// classes (ADD, LOGIC, HILO) are selected in the same cycle. MUL launches the
// fixed-latency multiplier, DIV launches the iterative divider. In both cases
// the pipeline is held with stall_req until the 64-bit result is ready, and a
// one-cycle write-back state then issues hilo_we.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   ex_valid   in   valid instruction present in EX
//   op_class   in   3-bit class: 0 ADD, 1 MUL, 2 DIV, 3 LOGIC, 4 HILO, 5..7 none
//   flush      in   cancel the EX instruction and any operation in flight
//   div_done   in   divider result valid (level, only looked at in DIV)
//   mult_start out  one-cycle multiplier start pulse
//   div_start  out  one-cycle divider start pulse
//   div_cancel out  one-cycle divider abort pulse
//   select     out  one-hot result select (adder, mult, div, logic, hilo) or zero
//   stall_req  out  hold IF/ID/EX this cycle
//   hilo_we    out  write the mult/div result into HI/LO this cycle
//   busy       out  controller not idle
//
// All outputs are combinational from the state, the registered counter/kind
// and the inputs, so IDLE decode is visible in the same cycle.
module ex_muldiv_ctrl #(
    parameter int unsigned MULT_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ex_valid,
    input  logic [2:0] op_class,
    input  logic       flush,
    input  logic       div_done,
    output logic       mult_start,
    output logic       div_start,
    output logic       div_cancel,
    output logic [4:0] select,
    output logic       stall_req,
    output logic       hilo_we,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        WB   = 2'd3
    } state_t;

    // Counter preload: the first MULT cycle sees MULT_LAT-1, so the machine
    // spends exactly MULT_LAT cycles in MULT before write-back.
    localparam logic [3:0] MULT_INIT = 4'(MULT_LAT - 1);

    localparam logic [4:0] SEL_NONE  = 5'b00000;
    localparam logic [4:0] SEL_ADD   = 5'b00001;
    localparam logic [4:0] SEL_MULT  = 5'b00010;
    localparam logic [4:0] SEL_DIV   = 5'b00100;
    localparam logic [4:0] SEL_LOGIC = 5'b01000;
    localparam logic [4:0] SEL_HILO  = 5'b10000;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] count_r;
    logic [3:0] count_next_s;
    // kind_r: 1'b0 = multiply in flight, 1'b1 = divide in flight
    logic       kind_r;
    logic       kind_next_s;

    // State, latency counter and operation-kind registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            count_r <= 4'd0;
            kind_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            kind_r  <= kind_next_s;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        kind_next_s  = kind_r;
        mult_start   = 1'b0;
        div_start    = 1'b0;
        div_cancel   = 1'b0;
        select       = SEL_NONE;
        stall_req    = 1'b0;
        hilo_we      = 1'b0;
        busy         = 1'b0;

        case (state_r)
            IDLE: begin
                if (ex_valid && !flush) begin
                    case (op_class)
                        3'd0: select = SEL_ADD;
                        3'd3: select = SEL_LOGIC;
                        3'd4: select = SEL_HILO;
                        3'd1: begin
                            mult_start   = 1'b1;
                            stall_req    = 1'b1;
                            kind_next_s  = 1'b0;
                            count_next_s = MULT_INIT;
                            state_next_s = MULT;
                        end
                        3'd2: begin
                            div_start    = 1'b1;
                            stall_req    = 1'b1;
                            kind_next_s  = 1'b1;
                            state_next_s = DIV;
                        end
                        default: select = SEL_NONE;
                    endcase
                end else begin
                    state_next_s = IDLE;
                end
            end

            MULT: begin
                stall_req = 1'b1;
                busy      = 1'b1;
                if (flush) begin
                    // Product in flight is simply discarded.
                    state_next_s = IDLE;
                end else if (count_r == 4'd0) begin
                    state_next_s = WB;
                end else begin
                    count_next_s = count_r - 4'd1;
                end
            end

            DIV: begin
                stall_req = 1'b1;
                busy      = 1'b1;
                if (flush) begin
                    // Flush wins over a simultaneous div_done.
                    div_cancel   = 1'b1;
                    state_next_s = IDLE;
                end else if (div_done) begin
                    state_next_s = WB;
                end else begin
                    state_next_s = DIV;
                end
            end

            WB: begin
                busy         = 1'b1;
                select       = kind_r ? SEL_DIV : SEL_MULT;
                hilo_we      = !flush;
                state_next_s = IDLE;
            end

            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Self-checking bench for ex_muldiv_ctrl. Two instances share the inputs:
// dut (MULT_LAT=2) and dut1 (MULT_LAT=1). Expected output words are pushed to
// a scoreboard queue as each cycle's stimulus is driven and popped/compared on
// the falling edge. Output word layout:
//   [10] mult_start [9] div_start [8] div_cancel [7:3] select
//   [2] stall_req [1] hilo_we [0] busy
module tb_ex_muldiv_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ex_valid = 1'b0;
    logic [2:0] op_class = 3'd0;
    logic       flush = 1'b0;
    logic       div_done = 1'b0;

    logic       ms0, ds0, dc0, st0, we0, bz0;
    logic [4:0] sel0;
    logic       ms1, ds1, dc1, st1, we1, bz1;
    logic [4:0] sel1;

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(.MULT_LAT(2)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .op_class(op_class),
        .flush(flush), .div_done(div_done),
        .mult_start(ms0), .div_start(ds0), .div_cancel(dc0), .select(sel0),
        .stall_req(st0), .hilo_we(we0), .busy(bz0)
    );

    ex_muldiv_ctrl #(.MULT_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .op_class(op_class),
        .flush(flush), .div_done(div_done),
        .mult_start(ms1), .div_start(ds1), .div_cancel(dc1), .select(sel1),
        .stall_req(st1), .hilo_we(we1), .busy(bz1)
    );

    logic [10:0] got0, got1;
    assign got0 = {ms0, ds0, dc0, sel0, st0, we0, bz0};
    assign got1 = {ms1, ds1, dc1, sel1, st1, we1, bz1};

    // Expected output words
    localparam logic [10:0] Z      = 11'b000_00000_000;
    localparam logic [10:0] E_ADD  = 11'b000_00001_000;
    localparam logic [10:0] E_LOG  = 11'b000_01000_000;
    localparam logic [10:0] E_HILO = 11'b000_10000_000;
    localparam logic [10:0] E_MS   = 11'b100_00000_100;
    localparam logic [10:0] E_DS   = 11'b010_00000_100;
    localparam logic [10:0] E_BUSY = 11'b000_00000_101;
    localparam logic [10:0] E_DC   = 11'b001_00000_101;
    localparam logic [10:0] E_WBM  = 11'b000_00010_011;
    localparam logic [10:0] E_WBMF = 11'b000_00010_001;
    localparam logic [10:0] E_WBD  = 11'b000_00100_011;

    typedef struct {
        logic        r;
        logic        ev;
        logic [2:0]  op;
        logic        fl;
        logic        dd;
        logic [10:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [10:0] exp;
        logic        which;
        string       name;
    } sb_t;

    sb_t  sb_q[$];
    int   compared = 0;
    int   mismatched = 0;
    logic [10:0] prev0 = 11'd0;

    task automatic cmp(input logic [10:0] got, input logic [10:0] exp, input string name);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard drain plus invariant checks on the MULT_LAT=2 instance.
    always @(negedge clk) begin
        sb_t item;
        logic bad;
        if (sb_q.size() > 0) begin
            item = sb_q.pop_front();
            cmp(item.which ? got1 : got0, item.exp, item.name);
        end
        bad = (got0[10] & prev0[10]) | (got0[9] & prev0[9]) | (got0[8] & prev0[8]) |
              (got0[1] & prev0[1]) | ($countones(got0[7:3]) > 1) | (got0[2] & got0[1]);
        compared++;
        if (bad) begin
            mismatched++;
            $display("FAIL invariant: got %b prev %b at %0t", got0, prev0, $time);
        end
        prev0 = got0;
    end

    // Drive one cycle of stimulus and queue the expected outputs for it.
    task automatic step(input logic r, input logic ev, input logic [2:0] op,
                        input logic fl, input logic dd, input logic [10:0] exp,
                        input logic which, input string name);
        sb_t item;
        rst      = r;
        ex_valid = ev;
        op_class = op;
        flush    = fl;
        div_done = dd;
        item.exp   = exp;
        item.which = which;
        item.name  = name;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_reset();
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, Z, 1'b0, "reset_hold");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z, 1'b0, "after_reset");
    endtask

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 1'b0, 1'b0, Z,      "rst_idle"};
        tbl[1]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z,      "first_after_rst"};
        tbl[2]  = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_ADD,  "dec_add"};
        tbl[3]  = '{1'b0, 1'b1, 3'd3, 1'b0, 1'b0, E_LOG,  "dec_logic"};
        tbl[4]  = '{1'b0, 1'b1, 3'd4, 1'b0, 1'b0, E_HILO, "dec_hilo"};
        tbl[5]  = '{1'b0, 1'b1, 3'd6, 1'b0, 1'b0, Z,      "dec_cls6"};
        tbl[6]  = '{1'b0, 1'b1, 3'd5, 1'b0, 1'b0, Z,      "dec_cls5"};
        tbl[7]  = '{1'b0, 1'b1, 3'd7, 1'b1, 1'b1, Z,      "dec_cls7"};
        tbl[8]  = '{1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z,      "idle_invalid"};
        tbl[9]  = '{1'b0, 1'b1, 3'd0, 1'b1, 1'b0, Z,      "idle_flush_add"};
        tbl[10] = '{1'b0, 1'b1, 3'd1, 1'b1, 1'b0, Z,      "idle_flush_mul"};
        tbl[11] = '{1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_ADD,  "add_after_flush"};

        @(posedge clk);
        #1;

        // Reset state and single-cycle decode table
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].r, tbl[i].ev, tbl[i].op, tbl[i].fl, tbl[i].dd,
                 tbl[i].exp, 1'b0, tbl[i].name);
        end

        // MUL, MULT_LAT=2: start t, stall t..t+2, WB t+3, idle t+4
        idle_reset();
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b0, "mul2_start");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, E_BUSY, 1'b0, "mul2_c1");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b0, "mul2_c2");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_WBM,  1'b0, "mul2_wb");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_ADD,  1'b0, "mul2_next_add");

        // MUL, MULT_LAT=1: WB at t+2
        idle_reset();
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b1, "mul1_start");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b1, "mul1_c1");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_WBM,  1'b1, "mul1_wb");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_ADD,  1'b1, "mul1_next_add");

        // DIV with div_done at t+33, held into t+35
        idle_reset();
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, E_DS, 1'b0, "div_start");
        for (int i = 1; i <= 32; i++) begin
            step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, E_BUSY, 1'b0, "div_wait");
        end
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b1, E_BUSY, 1'b0, "div_done_cycle");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, E_WBD,  1'b0, "div_wb");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, Z,      1'b0, "div_done_ignored");

        // DIV flushed together with div_done at t+5
        idle_reset();
        step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, E_DS, 1'b0, "divf_start");
        for (int i = 1; i <= 4; i++) begin
            step(1'b0, 1'b1, 3'd2, 1'b0, 1'b0, E_BUSY, 1'b0, "divf_wait");
        end
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b1, E_DC,  1'b0, "divf_cancel");
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, E_ADD, 1'b0, "divf_next_add");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z,     1'b0, "divf_idle");

        // Async reset in the middle of the cycle after a MUL start
        idle_reset();
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS, 1'b0, "mulr_start");
        ex_valid = 1'b0;
        #1;
        cmp(got0, E_BUSY, "mulr_before_rst");
        rst = 1'b1;
        #1;
        cmp(got0, Z, "mulr_rst_immediate");
        cmp(got1, Z, "mulr_rst_immediate_lat1");
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, Z, 1'b0, "mulr_rst_hold");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z, 1'b0, "mulr_no_wb");
        end

        // Flush during MULT: stall kept that cycle, no write-back afterwards
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b0, "mulf_start");
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, E_BUSY, 1'b0, "mulf_flush");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z, 1'b0, "mulf_no_wb");
        end

        // Flush during WB: hilo_we suppressed, select still driven
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b0, "wbf_start");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b0, "wbf_c1");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b0, "wbf_c2");
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, E_WBMF, 1'b0, "wbf_wb_flushed");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z,      1'b0, "wbf_idle");

        // Back-to-back MUL: second start MULT_LAT+2 cycles after the first
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b0, "b2b_start1");
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_BUSY, 1'b0, "b2b_c1");
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_BUSY, 1'b0, "b2b_c2");
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_WBM,  1'b0, "b2b_wb1");
        step(1'b0, 1'b1, 3'd1, 1'b0, 1'b0, E_MS,   1'b0, "b2b_start2");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b0, "b2b_c5");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E_BUSY, 1'b0, "b2b_c6");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, E_WBM,  1'b0, "b2b_wb2");
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, Z,      1'b0, "b2b_idle");

        // let the last queued entry drain on the falling edge
        #6;
        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_ctrl.md
Name: ex_muldiv_ctrl

Overview:
- Sequencing controller for the EX-stage result mux and its multi-cycle multiply/divide resources.
- Decodes the EX operation class and drives the 5-bit one-hot result select.
- Starts the multiplier (fixed latency) or the iterative divider (done-handshake), then holds the pipeline with stall_req until the 64-bit result is ready.
- Issues a one-cycle HI/LO write at completion. Handles flush and reset mid-operation.

Parameters:
- MULT_LAT, 2, multiplier latency in cycles from mult_start to valid product; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- ex_valid  in  1  valid instruction present in EX this cycle
- op_class  in  3  0=ADD, 1=MUL, 2=DIV, 3=LOGIC, 4=HILO, 5..7=none
- flush  in  1  cancel the instruction in EX and any operation in flight
- div_done  in  1  divider quotient/remainder valid (level; sampled only in DIV)
- mult_start  out  1  one-cycle multiplier start pulse
- div_start  out  1  one-cycle divider start pulse
- div_cancel  out  1  one-cycle divider abort pulse
- select  out  5  one-hot: 00001 adder, 00010 mult, 00100 div, 01000 logic, 10000 hilo, 00000 none
- stall_req  out  1  hold IF/ID/EX this cycle
- hilo_we  out  1  write mult_div_result into HI/LO this cycle
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset: FSM=IDLE, counter=0, latched kind=0; all outputs 0 while rst high and in the first cycle after, unless IDLE decode (below) applies.
- States: IDLE, MULT, DIV, WB. All outputs are combinational from state, the registered counter/kind, and inputs.
- IDLE, ex_valid=0 or flush=1: all outputs 0; stay IDLE.
- IDLE, ex_valid=1, flush=0:
  - ADD/LOGIC/HILO: select=00001/01000/10000 the same cycle; no stall; stay IDLE (0-cycle latency).
  - MUL: mult_start=1, stall_req=1, select=0. Latch kind=MUL, counter=MULT_LAT-1. Next state MULT.
  - DIV: div_start=1, stall_req=1, select=0. Latch kind=DIV. Next state DIV.
  - Class 5..7: select=0; no action.
- MULT: stall_req=1, busy=1, select=0.
  - counter!=0: decrement.
  - counter==0: next state WB. With MULT_LAT=1 this gives exactly one MULT cycle.
- DIV: stall_req=1, busy=1, select=0.
  - div_done=1: next state WB.
  - Otherwise stay; no timeout.
- WB (one cycle): select=00010 (MUL) or 00100 (DIV), hilo_we=1, stall_req=0, busy=1. Next state IDLE.
  - The new instruction arriving in EX is decoded from IDLE on the following cycle.
- Total latency, MUL: start cycle to hilo_we = MULT_LAT+1 cycles. Stall asserted for MULT_LAT+1 cycles, starting in the start cycle.
- Total latency, DIV: hilo_we comes 1 cycle after the cycle in which div_done is sampled high.
- Flush:
  - In MULT: next state IDLE, no hilo_we; the product is discarded.
  - In DIV: div_cancel=1 that cycle; next state IDLE. Flush beats a simultaneous div_done.
  - In WB: hilo_we forced 0, select still driven; next state IDLE.
  - stall_req stays 1 during a flush cycle in MULT/DIV.
- div_done high in IDLE/MULT/WB: ignored.
- Async reset mid-operation:
  - Immediate return to IDLE with all outputs 0.
  - No div_cancel is issued; the divider shares rst.
- Invariants:
  - mult_start, div_start, div_cancel, hilo_we never high for two consecutive cycles.
  - select is one-hot or zero.
  - stall_req and hilo_we never both 1.

Test Plan:
- Reset then ex_valid=1, op_class=0 -> select=00001 same cycle, stall_req=0, busy=0. op_class=3 -> 01000; op_class=4 -> 10000; op_class=6 -> 00000.
- MULT_LAT=2, MUL issued at cycle t -> mult_start=1 at t; stall_req=1 at t..t+2; WB at t+3 with select=00010, hilo_we=1, stall_req=0; busy=0 at t+4. Repeat with MULT_LAT=1 -> hilo_we at t+2.
- DIV at t, div_done asserted at t+33 -> div_start at t only; stall_req=1 at t..t+33; hilo_we=1, select=00100 at t+34; div_done held high in t+35 ignored.
- DIV in flight, flush and div_done both high at t+5 -> div_cancel=1 at t+5, hilo_we never asserted, state IDLE at t+6; a following ADD at t+6 gets select=00001.
- MUL in flight, rst pulsed mid-cycle at t+1 -> all outputs 0 immediately, busy=0; no hilo_we afterward. Flush during WB -> hilo_we=0.
- Back-to-back MUL,MUL (second presented while stalled) -> two mult_start pulses separated by MULT_LAT+2 cycles, two hilo_we pulses, pulse-width invariants hold throughout.
